pc_next_unit: RTL

Parametrised successor to the combinational PC+offset adder. It holds the program-counter register and computes all next-PC candidates: sequential, branch, JAL, JALR and trap vector. It selects one by fixed priority and advances only on a completed fetch handshake with instruction memory. It flags and redirects misaligned control-transfer targets, and sits between the branch/decode logic and instruction memory.

---
 rtl/pc_next_unit_pkg.sv | 32 +++
 rtl/pc_target_adder.sv | 20 ++
 rtl/pc_next_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pc_next_unit_pkg.sv
// Shared types and constants for the program-counter next-address unit.
package pc_next_unit_pkg;

  // Sequencer states: BOOT after reset, FETCH while requesting, TRAP after a redirect.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  // Which next-PC candidate won the priority selection.
  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JAL  = 3'd2,
    SEL_JALR = 3'd3,
    SEL_TRAP = 3'd4
  } sel_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

  // A 16-bit aligned ISA only needs even targets; otherwise targets must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] low_bits,
                                         input int unsigned ialign);
    logic bad;
    if (ialign == 16) bad = low_bits[0];
    else              bad = (low_bits != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/pc_target_adder.sv
// Base + offset adder with optional clearing of bit 0 (used for JALR targets).
module pc_target_adder #(
  parameter int unsigned XLEN     = 32,
  parameter bit          CLR_BIT0 = 1'b0
) (
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] offset_i,
  output logic [XLEN-1:0] sum_o
);

  logic [XLEN-1:0] raw_sum;

  // Wrapping add; carry out is intentionally discarded.
  always_comb begin
    raw_sum = base_i + offset_i;
    sum_o   = raw_sum;
    if (CLR_BIT0) sum_o[0] = 1'b0;
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter register with next-PC selection, fetch handshake and
// misaligned-target redirection.
//
// Handshake: fetch_valid_o requests a fetch of pc_o; the request is
// accepted on a rising edge where fetch_valid_o && fetch_ready_i && !stall_i.
// Once raised in FETCH the request is held (and pc_o stays stable) until accepted.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEFAULT_TRAP_VEC),
  parameter int unsigned     IALIGN   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic            jal_i,
  input  logic            jalr_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_4_o,
  output logic [XLEN-1:0] target_o,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  output logic            misaligned_o,
  output logic [XLEN-1:0] misaligned_addr_o,
  output logic [1:0]      state_o
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  logic [XLEN-1:0] rel_sum;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] seq_pc;
  sel_e            sel;
  logic            check_align;
  logic            target_misaligned;
  logic            adv;

  // PC-relative path shared by branch and JAL (both are pc + imm).
  pc_target_adder #(.XLEN(XLEN), .CLR_BIT0(1'b0)) u_rel_adder (
    .base_i   (pc_q),
    .offset_i (imm_i),
    .sum_o    (rel_sum)
  );

  // Register-relative path for JALR with bit 0 forced low.
  pc_target_adder #(.XLEN(XLEN), .CLR_BIT0(1'b1)) u_jalr_adder (
    .base_i   (rs1_i),
    .offset_i (imm_i),
    .sum_o    (jalr_sum)
  );

  // Fixed-priority candidate selection and alignment check of the winner.
  always_comb begin
    seq_pc = pc_q + XLEN'(4);
    sel    = SEL_SEQ;
    if (trap_i)              sel = SEL_TRAP;
    else if (jalr_i)         sel = SEL_JALR;
    else if (jal_i)          sel = SEL_JAL;
    else if (branch_taken_i) sel = SEL_BR;

    case (sel)
      SEL_TRAP: target_o = TRAP_VEC;
      SEL_JALR: target_o = jalr_sum;
      SEL_JAL:  target_o = rel_sum;
      SEL_BR:   target_o = rel_sum;
      default:  target_o = seq_pc;
    endcase

    // Sequential fall-through and the trap vector are never checked.
    check_align       = (sel == SEL_BR) || (sel == SEL_JAL) || (sel == SEL_JALR);
    target_misaligned = check_align && is_misaligned(target_o[1:0], IALIGN);
  end

  // Next-state, next-PC and misalignment bookkeeping.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
    adv        = (state_q == ST_FETCH) && fetch_ready_i && !stall_i;

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (adv) begin
          if (sel == SEL_TRAP) begin
            pc_d    = TRAP_VEC;
            state_d = ST_TRAP;
          end else if (target_misaligned) begin
            pc_d       = TRAP_VEC;
            mis_d      = 1'b1;
            mis_addr_d = target_o;
            state_d    = ST_TRAP;
          end else begin
            pc_d = target_o;
          end
        end
      end
      ST_TRAP: state_d = ST_FETCH;
      default: state_d = ST_BOOT;
    endcase
  end

  // State and PC registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign pc_o              = pc_q;
  assign pc_plus_4_o       = seq_pc;
  assign fetch_valid_o     = (state_q == ST_FETCH);
  assign misaligned_o      = mis_q;
  assign misaligned_addr_o = mis_addr_q;
  assign state_o           = state_q;

endmodule
